// File: rtl/sha256_bus_initiator.sv
// Bus master that feeds 512-bit message blocks into the SHA-256 register slave.
// For each block it writes the block words and CTRL, then polls STATUS. On the
// last block of a message it also reads back the 256-bit digest and offers it
// downstream. Only one bus transaction is outstanding at any time.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for an upstream block (blk_ready_o high)
// ST_WR_BLK  | writing the block words, ascending addresses
// ST_WR_CTRL | writing {last, first, enable} to CTRL
// ST_POLL    | reading STATUS until idle (or digest_valid on the last block)
// ST_RD_DIG  | reading the digest words, ascending addresses
// ST_OUT     | digest presented downstream until it is consumed
module sha256_bus_initiator #(
    parameter int unsigned          DataWidth = 64,  // 32 or 64
    parameter int unsigned          AddrWidth = 32,
    parameter int unsigned          DataBytes = DataWidth >> 3,
    parameter logic [AddrWidth-1:0] BaseAddr  = '0,
    parameter int unsigned          PollLimit = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    // upstream block stream
    input  logic                 blk_valid_i,
    output logic                 blk_ready_o,
    input  logic [511:0]         blk_data_i,
    input  logic                 blk_first_i,
    input  logic                 blk_last_i,
    // downstream digest
    output logic                 digest_valid_o,
    input  logic                 digest_ready_i,
    output logic [255:0]         digest_o,
    output logic                 error_o,
    // request/response bus
    output logic [DataWidth-1:0] m_reqdata_o,
    output logic [AddrWidth-1:0] m_reqaddr_o,
    output logic                 m_reqvalid_o,
    output logic                 m_reqwrite_o,
    input  logic                 m_reqready_i,
    output logic [DataBytes-1:0] m_reqstrobe_o,
    output logic                 m_rspready_o,
    input  logic                 m_rspvalid_i,
    input  logic [DataWidth-1:0] m_rspdata_i,
    input  logic                 m_rsperror_i
);

    localparam int unsigned NumBlkWords = 512 / DataWidth;
    localparam int unsigned NumDigWords = 256 / DataWidth;
    localparam int unsigned AddrShift   = $clog2(DataBytes);
    localparam int unsigned PollW       = $clog2(PollLimit + 1);

    localparam logic [AddrWidth-1:0] OffsCtrl   = AddrWidth'(32'h40);
    localparam logic [AddrWidth-1:0] OffsStatus = AddrWidth'(32'h48);
    localparam logic [AddrWidth-1:0] OffsDigest = AddrWidth'(32'h50);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BLK,
        ST_WR_CTRL,
        ST_POLL,
        ST_RD_DIG,
        ST_OUT
    } state_e;

    state_e state_q, state_d;

    logic [3:0]           beat_q, beat_d;
    logic [PollW-1:0]     poll_q, poll_d;
    logic [511:0]         blk_q, blk_d;
    logic                 first_q, first_d;
    logic                 last_q, last_d;
    logic [255:0]         dig_q, dig_d;
    logic                 err_q, err_d;
    logic                 req_valid_q, req_valid_d;
    logic                 req_write_q, req_write_d;
    logic [AddrWidth-1:0] req_addr_q, req_addr_d;
    logic [DataWidth-1:0] req_data_q, req_data_d;
    logic                 rsp_wait_q, rsp_wait_d;
    logic                 rdy_en_q;

    logic                 bus_free;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 poll_done;
    logic [AddrWidth-1:0] beat_offs;

    assign bus_free  = !req_valid_q && !rsp_wait_q;
    assign req_fire  = req_valid_q && m_reqready_i;
    assign rsp_fire  = rsp_wait_q && m_rspvalid_i;
    assign poll_done = last_q ? m_rspdata_i[1] : m_rspdata_i[0];
    assign beat_offs = AddrWidth'(beat_q) << AddrShift;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and bus request registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_q      <= '0;
            poll_q      <= '0;
            blk_q       <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            dig_q       <= '0;
            err_q       <= 1'b0;
            req_valid_q <= 1'b0;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
            rsp_wait_q  <= 1'b0;
        end else begin
            beat_q      <= beat_d;
            poll_q      <= poll_d;
            blk_q       <= blk_d;
            first_q     <= first_d;
            last_q      <= last_d;
            dig_q       <= dig_d;
            err_q       <= err_d;
            req_valid_q <= req_valid_d;
            req_write_q <= req_write_d;
            req_addr_q  <= req_addr_d;
            req_data_q  <= req_data_d;
            rsp_wait_q  <= rsp_wait_d;
        end
    end

    // Keeps blk_ready_o low while reset is asserted and for the first cycle after.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
        end
    end

    // Next-state, request issue and response handling.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        poll_d      = poll_q;
        blk_d       = blk_q;
        first_d     = first_q;
        last_d      = last_q;
        dig_d       = dig_q;
        err_d       = err_q;
        req_valid_d = req_valid_q;
        req_write_d = req_write_q;
        req_addr_d  = req_addr_q;
        req_data_d  = req_data_q;
        rsp_wait_d  = rsp_wait_q;

        // Request accepted: drop valid, start waiting for the response.
        if (req_fire) begin
            req_valid_d = 1'b0;
            rsp_wait_d  = 1'b1;
        end
        if (rsp_fire) begin
            rsp_wait_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (blk_valid_i && rdy_en_q) begin
                    blk_d   = blk_data_i;
                    first_d = blk_first_i;
                    last_d  = blk_last_i;
                    err_d   = 1'b0;
                    beat_d  = '0;
                    state_d = ST_WR_BLK;
                end
            end

            ST_WR_BLK: begin
                if (bus_free) begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b1;
                    req_addr_d  = BaseAddr + beat_offs;
                    req_data_d  = blk_q[511 -: DataWidth];
                end
                if (rsp_fire) begin
                    if (m_rsperror_i) begin
                        err_d   = 1'b1;
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        // Shift so the next word is always at the top.
                        blk_d = blk_q << DataWidth;
                        if (beat_q == 4'(NumBlkWords - 1)) begin
                            beat_d  = '0;
                            state_d = ST_WR_CTRL;
                        end else begin
                            beat_d = beat_q + 4'd1;
                        end
                    end
                end
            end

            ST_WR_CTRL: begin
                if (bus_free) begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b1;
                    req_addr_d  = BaseAddr + OffsCtrl;
                    req_data_d  = DataWidth'({last_q, first_q, 1'b1});
                end
                if (rsp_fire) begin
                    if (m_rsperror_i) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        poll_d  = '0;
                        state_d = ST_POLL;
                    end
                end
            end

            ST_POLL: begin
                if (bus_free) begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_addr_d  = BaseAddr + OffsStatus;
                    req_data_d  = '0;
                end
                if (rsp_fire) begin
                    if (m_rsperror_i) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (poll_done) begin
                        beat_d  = '0;
                        state_d = last_q ? ST_RD_DIG : ST_IDLE;
                    end else if (poll_q >= PollW'(PollLimit - 1)) begin
                        // This was the PollLimit-th unsuccessful read.
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (poll_q != PollW'(PollLimit)) begin
                        poll_d = poll_q + 1'b1;
                    end
                end
            end

            ST_RD_DIG: begin
                if (bus_free) begin
                    req_valid_d = 1'b1;
                    req_write_d = 1'b0;
                    req_addr_d  = BaseAddr + OffsDigest + beat_offs;
                    req_data_d  = '0;
                end
                if (rsp_fire) begin
                    if (m_rsperror_i) begin
                        err_d   = 1'b1;
                        beat_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        // Words arrive first-to-last; shifting in from the
                        // bottom leaves word 0 in the top slice.
                        dig_d = {dig_q[255-DataWidth:0], m_rspdata_i};
                        if (beat_q == 4'(NumDigWords - 1)) begin
                            beat_d  = '0;
                            state_d = ST_OUT;
                        end else begin
                            beat_d = beat_q + 4'd1;
                        end
                    end
                end
            end

            ST_OUT: begin
                if (digest_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign blk_ready_o    = (state_q == ST_IDLE) && rdy_en_q;
    assign digest_valid_o = (state_q == ST_OUT);
    assign digest_o       = dig_q;
    assign error_o        = err_q;
    assign m_reqdata_o    = req_data_q;
    assign m_reqaddr_o    = req_addr_q;
    assign m_reqvalid_o   = req_valid_q;
    assign m_reqwrite_o   = req_write_q;
    assign m_reqstrobe_o  = {DataBytes{req_valid_q & req_write_q}};
    assign m_rspready_o   = rsp_wait_q;

endmodule

// File: tb/tb_sha256_bus_initiator.sv
// Directed bench for sha256_bus_initiator with a behavioural register slave.
// The slave logs every accepted request and serves a preloaded digest, so the
// bench checks bus sequencing, data placement and digest assembly.
module tb_sha256_bus_initiator;

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
    localparam logic [255:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] NIST_B1 = {
        448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
        64'h8000000000000000};
    localparam logic [511:0] NIST_B2 = {448'h0, 64'h1c0};
    localparam logic [255:0] NIST_DIG =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid_i, blk_ready_o, blk_first_i, blk_last_i;
    logic [511:0] blk_data_i;
    logic         digest_valid_o, digest_ready_i, error_o;
    logic [255:0] digest_o;
    logic [63:0]  m_reqdata_o;
    logic [31:0]  m_reqaddr_o;
    logic         m_reqvalid_o, m_reqwrite_o, m_reqready_i;
    logic [7:0]   m_reqstrobe_o;
    logic         m_rspready_o, m_rspvalid_i, m_rsperror_i;
    logic [63:0]  m_rspdata_i;

    always #5 clk = ~clk;

    sha256_bus_initiator #(
        .DataWidth(64), .AddrWidth(32), .BaseAddr(32'h0), .PollLimit(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_data_i(blk_data_i),
        .blk_first_i(blk_first_i), .blk_last_i(blk_last_i),
        .digest_valid_o(digest_valid_o), .digest_ready_i(digest_ready_i),
        .digest_o(digest_o), .error_o(error_o),
        .m_reqdata_o(m_reqdata_o), .m_reqaddr_o(m_reqaddr_o), .m_reqvalid_o(m_reqvalid_o),
        .m_reqwrite_o(m_reqwrite_o), .m_reqready_i(m_reqready_i),
        .m_reqstrobe_o(m_reqstrobe_o), .m_rspready_o(m_rspready_o),
        .m_rspvalid_i(m_rspvalid_i), .m_rspdata_i(m_rspdata_i), .m_rsperror_i(m_rsperror_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // slave configuration and log
    int           stall_cfg   = 0;
    bit           rand_dly    = 0;
    int           n_not_ready = 2;
    int           err_wr_idx  = -1;
    logic [255:0] exp_dig     = ABC_DIG;
    int           wr_cnt, stat_cnt;
    bit           dig_rd_seen;
    int           stable_viol = 0, overlap_viol = 0, strobe_viol = 0;
    logic [31:0]  lg_addr[$];
    logic [63:0]  lg_data[$];
    logic         lg_wr[$];

    function automatic logic [96:0] lg_entry(input int i);
        if (i < lg_addr.size()) return {lg_wr[i], lg_addr[i], lg_data[i]};
        return '1;
    endfunction

    task automatic clear_log();
        lg_addr.delete(); lg_data.delete(); lg_wr.delete();
        wr_cnt = 0; stat_cnt = 0; dig_rd_seen = 0;
    endtask

    // Slave: decisions made on the falling edge take effect at the next rising edge.
    initial begin
        bit          rsp_pend = 0, seen = 0, busy;
        int          rsp_dly = 0, stall_left = 0, j;
        logic [63:0] rsp_data;
        logic        rsp_err;
        logic [104:0] saved;
        m_reqready_i = 0; m_rspvalid_i = 0; m_rspdata_i = '0; m_rsperror_i = 0;
        rsp_data = '0; rsp_err = 0; saved = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rsp_pend = 0; seen = 0; stall_left = 0;
                m_reqready_i = 0; m_rspvalid_i = 0; m_rsperror_i = 0;
                continue;
            end
            busy = rsp_pend;
            m_rspvalid_i = 0; m_rsperror_i = 0;
            if (rsp_pend) begin
                if (rsp_dly > 0) rsp_dly--;
                else begin
                    m_rspvalid_i = 1; m_rspdata_i = rsp_data; m_rsperror_i = rsp_err;
                    if (m_rspready_o) rsp_pend = 0;
                end
            end
            m_reqready_i = 0;
            if (m_reqvalid_o) begin
                if (busy) overlap_viol++;
                else begin
                    if (!seen) begin
                        seen = 1; stall_left = stall_cfg;
                        saved = {m_reqwrite_o, m_reqaddr_o, m_reqdata_o, m_reqstrobe_o};
                    end else if (saved !== {m_reqwrite_o, m_reqaddr_o, m_reqdata_o, m_reqstrobe_o})
                        stable_viol++;
                    if (stall_left > 0) stall_left--;
                    else begin
                        m_reqready_i = 1; seen = 0;
                        if (m_reqstrobe_o !== (m_reqwrite_o ? 8'hff : 8'h00)) strobe_viol++;
                        lg_addr.push_back(m_reqaddr_o); lg_data.push_back(m_reqdata_o);
                        lg_wr.push_back(m_reqwrite_o);
                        rsp_err = 0; rsp_data = '0;
                        if (m_reqwrite_o) begin
                            rsp_err = (wr_cnt == err_wr_idx);
                            wr_cnt++;
                        end else if (m_reqaddr_o == 32'h48) begin
                            rsp_data = (stat_cnt < n_not_ready) ? 64'h0 : 64'h3;
                            stat_cnt++;
                        end else if (m_reqaddr_o >= 32'h50 && m_reqaddr_o < 32'h70) begin
                            j = int'((m_reqaddr_o - 32'h50) >> 3);
                            rsp_data = exp_dig[255-64*j -: 64];
                            dig_rd_seen = 1;
                        end else rsp_data = 64'hdead;
                        rsp_pend = 1;
                        rsp_dly = rand_dly ? int'($urandom_range(7, 0)) : 0;
                    end
                end
            end else if (seen) begin
                stable_viol++;
                seen = 0;
            end
        end
    end

    task automatic send_block(input logic [511:0] d, input logic f, input logic l);
        @(negedge clk);
        blk_data_i = d; blk_first_i = f; blk_last_i = l; blk_valid_i = 1;
        for (int i = 0; i < 100 && !blk_ready_o; i++) @(negedge clk);
        @(negedge clk);
        blk_valid_i = 0; blk_data_i = '0; blk_first_i = 0; blk_last_i = 0;
    endtask

    task automatic wait_done(input string tag);
        bit ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            if (digest_valid_o || blk_ready_o) ok = 1;
            else @(negedge clk);
        end
        check_eq({tag, "_done"}, 256'(ok), 256'(1));
    endtask

    task automatic chk_writes(input string tag, input logic [511:0] d, input logic [63:0] ctrl);
        for (int i = 0; i < 8; i++)
            check_eq($sformatf("%s_w%0d", tag, i), 256'(lg_entry(i)),
                     256'({1'b1, 32'(i * 8), d[511-64*i -: 64]}));
        check_eq({tag, "_ctrl"}, 256'(lg_entry(8)), 256'({1'b1, 32'h40, ctrl}));
    endtask

    task automatic chk_reads(input string tag, input int n_stat_exp, input int n_dig_exp);
        int n_stat = 0, n_dig = 0;
        bit seq_ok = 1;
        for (int i = 0; i < lg_addr.size(); i++) begin
            if (!lg_wr[i] && lg_addr[i] == 32'h48) n_stat++;
            if (!lg_wr[i] && lg_addr[i] >= 32'h50) begin
                if (lg_addr[i] != 32'h50 + 32'(8 * n_dig)) seq_ok = 0;
                n_dig++;
            end
        end
        check_eq({tag, "_nstatus"}, 256'(n_stat), 256'(n_stat_exp));
        check_eq({tag, "_ndigest"}, 256'(n_dig), 256'(n_dig_exp));
        check_eq({tag, "_dig_addr_seq"}, 256'(seq_ok), 256'(1));
    endtask

    task automatic release_digest();
        @(negedge clk); digest_ready_i = 1;
        @(negedge clk); digest_ready_i = 0;
    endtask

    initial begin
        int unstable;
        logic [255:0] cap;
        rst_n = 0; blk_valid_i = 0; blk_data_i = '0; blk_first_i = 0; blk_last_i = 0;
        digest_ready_i = 0;
        clear_log();
        #12;
        check_eq("rst_flags", 256'({blk_ready_o, digest_valid_o, error_o, m_reqvalid_o, m_rspready_o}), 256'(0));
        check_eq("rst_digest", digest_o, 256'(0));
        @(negedge clk); rst_n = 1;
        @(negedge clk); @(negedge clk);
        check_eq("idle_blk_ready", 256'(blk_ready_o), 256'(1));

        // "abc", single block, zero-wait slave
        clear_log(); exp_dig = ABC_DIG;
        send_block(ABC_BLK, 1, 1);
        wait_done("abc");
        check_eq("abc_dvalid", 256'(digest_valid_o), 256'(1));
        check_eq("abc_digest", digest_o, ABC_DIG);
        check_eq("abc_word0", 256'(lg_entry(0)), 256'({1'b1, 32'h0, 64'h6162638000000000}));
        check_eq("abc_word7", 256'(lg_entry(7)), 256'({1'b1, 32'h38, 64'h18}));
        chk_writes("abc", ABC_BLK, 64'h7);
        chk_reads("abc", 3, 4);
        unstable = 0; cap = digest_o;
        repeat (10) begin
            @(negedge clk);
            if (!digest_valid_o || digest_o !== cap) unstable++;
        end
        check_eq("abc_hold_stable", 256'(unstable), 256'(0));
        release_digest();
        check_eq("abc_out_to_idle", 256'({digest_valid_o, blk_ready_o}), 256'(2'b01));

        // two-block NIST message
        clear_log(); exp_dig = NIST_DIG;
        send_block(NIST_B1, 1, 0);
        wait_done("nist1");
        check_eq("nist1_flags", 256'({digest_valid_o, blk_ready_o, error_o}), 256'(3'b010));
        chk_writes("nist1", NIST_B1, 64'h3);
        chk_reads("nist1", 3, 0);
        clear_log();
        send_block(NIST_B2, 0, 1);
        wait_done("nist2");
        chk_writes("nist2", NIST_B2, 64'h5);
        check_eq("nist2_word7", 256'(lg_entry(7)), 256'({1'b1, 32'h38, 64'h1c0}));
        check_eq("nist2_digest", digest_o, NIST_DIG);
        release_digest();

        // stalled request channel, random response delay
        clear_log(); exp_dig = NIST_DIG; stall_cfg = 5; rand_dly = 1;
        send_block(NIST_B1, 1, 0);
        wait_done("stall1");
        clear_log();
        send_block(NIST_B2, 0, 1);
        wait_done("stall2");
        check_eq("stall_digest", digest_o, NIST_DIG);
        chk_reads("stall", 3, 4);
        check_eq("stall_req_stable", 256'(stable_viol), 256'(0));
        check_eq("stall_one_outstanding", 256'(overlap_viol), 256'(0));
        release_digest();
        stall_cfg = 0; rand_dly = 0;

        // bus error on the third block write
        clear_log(); exp_dig = ABC_DIG; err_wr_idx = 2;
        send_block(ABC_BLK, 1, 1);
        wait_done("err");
        repeat (3) @(negedge clk);
        check_eq("err_flags", 256'({error_o, digest_valid_o, blk_ready_o}), 256'(3'b101));
        check_eq("err_nreq", 256'(lg_addr.size()), 256'(3));
        err_wr_idx = -1;
        clear_log();
        send_block(ABC_BLK, 1, 1);
        check_eq("err_cleared", 256'(error_o), 256'(0));
        wait_done("err_next");
        check_eq("err_next_digest", digest_o, ABC_DIG);
        release_digest();

        // poll timeout
        clear_log(); n_not_ready = 99;
        send_block(ABC_BLK, 1, 1);
        wait_done("poll");
        check_eq("poll_flags", 256'({error_o, digest_valid_o}), 256'(2'b10));
        chk_reads("poll", 4, 0);
        n_not_ready = 2;

        // asynchronous reset during digest readback
        clear_log(); rand_dly = 1;
        send_block(ABC_BLK, 1, 1);
        for (int i = 0; i < 500 && !dig_rd_seen; i++) @(negedge clk);
        check_eq("rst_reach_rd_dig", 256'(dig_rd_seen), 256'(1));
        #2 rst_n = 0;
        #1;
        check_eq("rst_async_bus", 256'({m_reqvalid_o, m_rspready_o, m_reqwrite_o, m_reqstrobe_o, m_reqaddr_o, m_reqdata_o}), 256'(0));
        check_eq("rst_async_flags", 256'({blk_ready_o, digest_valid_o, error_o}), 256'(0));
        check_eq("rst_async_digest", digest_o, 256'(0));
        repeat (3) @(negedge clk);
        rst_n = 1; rand_dly = 0;
        @(negedge clk); @(negedge clk);
        clear_log();
        send_block(ABC_BLK, 1, 1);
        wait_done("rst_after");
        check_eq("rst_after_digest", digest_o, ABC_DIG);
        chk_writes("rst_after", ABC_BLK, 64'h7);
        release_digest();

        check_eq("strobe_rules", 256'(strobe_viol), 256'(0));
        check_eq("one_outstanding", 256'(overlap_viol), 256'(0));
        check_eq("req_stable", 256'(stable_viol), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
